// File: rtl/uio_bus_arbiter_if.sv
// Bundle of requester-side and pad-side signals shared by uio_bus_arbiter.
// The master modport is the environment (user logic plus pads).
// The slave modport is the arbiter itself.
interface uio_bus_arbiter_if #(
  parameter int NREQ = 2
);
  logic                ena;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     wr;
  logic [8*NREQ-1:0]   wdata;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic [7:0]          rdata;
  logic                busy;
  logic [7:0]          uio_in;
  logic [7:0]          uio_out;
  logic [7:0]          uio_oe;

  modport master (
    output ena, req, wr, wdata, uio_in,
    input  gnt, done, rdata, busy, uio_out, uio_oe
  );

  modport slave (
    input  ena, req, wr, wdata, uio_in,
    output gnt, done, rdata, busy, uio_out, uio_oe
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter that shares the 8-bit bidirectional uio pad bus.
// One requester owns the bus at a time. A single TURN cycle, with the pads
// released, is inserted whenever the bus direction has to flip.
module uio_bus_arbiter #(
  parameter int NREQ = 2,
  parameter int HOLD = 2
) (
  input logic              clk,
  input logic              rst_n,
  uio_bus_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [NREQ-1:0] GNT_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            dir_q, dir_d;       // 1 = pads driven, 0 = pads sampled
  logic [PW-1:0]   ptr_q, ptr_d;       // round-robin search start
  logic            wr_q, wr_d;         // latched direction of current transfer
  logic [7:0]      data_q, data_d;     // latched write data
  logic [CW-1:0]   cnt_q, cnt_d;       // remaining XFER cycles minus one
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      out_q, out_d;

  // Per-requester view of the packed write-data vector.
  logic [7:0] wdata_arr [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_wdata
    assign wdata_arr[gi] = bus.wdata[8*gi +: 8];
  end

  logic          found;
  logic [PW-1:0] pick;
  logic [PW-1:0] pick_next;
  int            idx;

  // Search for the first active request starting at ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  assign pick_next = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;

  // Next-state logic and register updates for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rdata_d = rdata_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ena && found) begin
          ptr_d  = pick_next;
          wr_d   = bus.wr[pick];
          data_d = wdata_arr[pick];
          gnt_d  = GNT_ONE << pick;
          cnt_d  = CW'(HOLD - 1);
          if (bus.wr[pick] != dir_q) begin
            state_d = S_TURN;
          end else begin
            state_d = S_XFER;
            // The direction is already right, so the data goes onto the pads
            // in the first XFER cycle.
            if (bus.wr[pick]) out_d = wdata_arr[pick];
          end
        end
      end
      S_TURN: begin
        dir_d   = wr_q;
        if (wr_q) out_d = data_q;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = gnt_q;
          if (!wr_q) rdata_d = bus.uio_in;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset releases the pads at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      ptr_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= 8'h00;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= 8'h00;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
    end
  end

  // The pads follow dir everywhere except in TURN. During XFER dir already
  // equals the latched direction, because a mismatch always passes through TURN.
  assign bus.uio_oe  = (state_q == S_TURN) ? 8'h00 : {8{dir_q}};
  assign bus.uio_out = out_q;
  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed steps from the test plan, then random
// traffic. A transaction-level timeline model produces the expected outputs.
module tb_uio_bus_arbiter;
  localparam int NREQ = 2;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uio_bus_arbiter_if #(.NREQ(NREQ)) bus();
  uio_bus_arbiter #(.NREQ(NREQ), .HOLD(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // One expected output record per clock cycle.
  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [7:0]      oe;
    logic [7:0]      out;
    logic            busy;
    bit              sample;   // the read data is taken at the edge ending this cycle
  } rec_t;

  rec_t       cur;
  rec_t       sched[$];
  bit         m_dir;
  int         m_ptr;
  logic [7:0] m_out;
  logic [7:0] m_rdata;
  int         errors = 0;
  int         checks = 0;
  bit         autoclr;

  function automatic rec_t idle_rec();
    rec_t r;
    r.gnt = '0; r.done = '0; r.oe = m_dir ? 8'hFF : 8'h00;
    r.out = m_out; r.busy = 1'b0; r.sample = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    sched.delete();
    m_dir = 1'b0; m_ptr = 0; m_out = 8'h00; m_rdata = 8'h00;
    cur = idle_rec();
  endtask

  // Advance the model by one clock edge, using the inputs as they stand now.
  task automatic model_step();
    int w;
    bit wrb;
    logic [7:0] d;
    logic [NREQ-1:0] g;
    rec_t r;
    if (cur.sample) m_rdata = bus.uio_in;
    if (sched.size() > 0) begin
      cur = sched.pop_front();
    end else if (!cur.busy && bus.ena && bus.req != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      m_ptr = (w + 1) % NREQ;
      wrb = bus.wr[w];
      d = bus.wdata[8*w +: 8];
      g = '0; g[w] = 1'b1;
      if (wrb != m_dir) begin
        r.gnt = g; r.done = '0; r.oe = 8'h00; r.out = m_out; r.busy = 1'b1; r.sample = 1'b0;
        sched.push_back(r);
      end
      m_dir = wrb;
      if (wrb) m_out = d;
      for (int i = 0; i < HOLD; i++) begin
        r.gnt = g; r.done = '0; r.oe = wrb ? 8'hFF : 8'h00; r.out = m_out; r.busy = 1'b1;
        r.sample = (i == HOLD - 1) && !wrb;
        sched.push_back(r);
      end
      r.gnt = g; r.done = g; r.oe = wrb ? 8'hFF : 8'h00; r.out = m_out; r.busy = 1'b1; r.sample = 1'b0;
      sched.push_back(r);
      cur = sched.pop_front();
    end else begin
      cur = idle_rec();
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag);
    chk({tag, ".gnt"},    8'(bus.gnt),  8'(cur.gnt));
    chk({tag, ".done"},   8'(bus.done), 8'(cur.done));
    chk({tag, ".oe"},     bus.uio_oe,   cur.oe);
    chk({tag, ".out"},    bus.uio_out,  cur.out);
    chk({tag, ".busy"},   8'(bus.busy), 8'(cur.busy));
    chk({tag, ".rdata"},  bus.rdata,    m_rdata);
    chk({tag, ".onehot"}, 8'($onehot0(bus.gnt)), 8'd1);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_cycle(tag);
    if (autoclr) bus.req = bus.req & ~bus.done;
  endtask

  logic [NREQ-1:0] exp_order [4];
  int nd;

  initial begin
    bus.ena = 1'b0; bus.req = '0; bus.wr = '0; bus.wdata = '0; bus.uio_in = 8'h00;
    autoclr = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset");
    rst_n = 1'b1;

    // Write after reset: turnaround, two XFER cycles, then DONE.
    bus.ena = 1'b1; bus.req = 2'b01; bus.wr = 2'b01; bus.wdata = {8'h00, 8'hA5};
    tick("wr1");  chk("wr1.c1.oe", bus.uio_oe, 8'h00);
    tick("wr1");  chk("wr1.c2.out", bus.uio_out, 8'hA5);
    tick("wr1");
    tick("wr1");  chk("wr1.c4.done", 8'(bus.done), 8'h01);
    tick("wr1");  chk("wr1.c5.oe", bus.uio_oe, 8'hFF);

    // Read after the write: turnaround, then the sample lands in rdata.
    bus.req = 2'b10; bus.wr = 2'b00; bus.uio_in = 8'h3C;
    tick("rd1");  chk("rd1.turn.oe", bus.uio_oe, 8'h00);
    tick("rd1");
    tick("rd1");
    tick("rd1");  chk("rd1.done", 8'(bus.done), 8'h02); chk("rd1.rdata", bus.rdata, 8'h3C);
    tick("rd1");

    // Contention: both requesters write and hold req high.
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    autoclr = 1'b0; nd = 0;
    bus.req = 2'b11; bus.wr = 2'b11; bus.wdata = {8'h22, 8'h11};
    for (int c = 0; c < 40 && nd < 4; c++) begin
      tick("cont");
      if (bus.done != '0) begin
        chk("cont.order", 8'(bus.done), 8'(exp_order[nd]));
        nd++;
      end
    end
    chk("cont.count", 8'(nd), 8'd4);
    bus.req = '0;
    repeat (2) tick("cont");

    // Back-to-back writes from requester 0: no TURN, the pads stay driven.
    bus.req = 2'b01; bus.wr = 2'b01; bus.wdata = {8'h00, 8'h5A};
    for (int c = 0; c < 9; c++) begin
      tick("b2b");
      chk("b2b.oe", bus.uio_oe, 8'hFF);
    end
    bus.req = '0;
    repeat (3) tick("b2b");
    autoclr = 1'b1;

    // ena low blocks the grant. Raising it lets the next edge grant.
    bus.ena = 1'b0; bus.req = 2'b01; bus.wr = 2'b01; bus.wdata = {8'h00, 8'h77};
    for (int c = 0; c < 5; c++) begin
      tick("ena");
      chk("ena.gnt", 8'(bus.gnt), 8'h00);
      chk("ena.busy", 8'(bus.busy), 8'h00);
    end
    bus.ena = 1'b1;
    tick("ena");  chk("ena.grant", 8'(bus.gnt), 8'h01);
    repeat (4) tick("ena");

    // Reset pulse in the middle of a write XFER.
    bus.req = 2'b01; bus.wr = 2'b01; bus.wdata = {8'h00, 8'hC3};
    tick("rst");  chk("rst.pre.oe", bus.uio_oe, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.async.oe", bus.uio_oe, 8'h00);
    chk("rst.async.gnt", 8'(bus.gnt), 8'h00);
    chk("rst.async.out", bus.uio_out, 8'h00);
    model_reset();
    bus.req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.nodone", 8'(bus.done), 8'h00);
    check_cycle("rst.held");
    rst_n = 1'b1;
    bus.req = 2'b10; bus.wr = 2'b10; bus.wdata = {8'h99, 8'h00};
    tick("rst.fresh");  chk("rst.fresh.gnt", 8'(bus.gnt), 8'h02);
    repeat (5) tick("rst.fresh");

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req[i] && $urandom_range(0, 3) == 0) bus.req[i] = 1'b1;
      bus.wr     = NREQ'($urandom);
      bus.wdata  = (8*NREQ)'($urandom);
      bus.uio_in = 8'($urandom);
      bus.ena    = ($urandom_range(0, 7) != 0);
      tick("rand");
    end
    bus.req = '0; bus.ena = 1'b1;
    repeat (8) tick("drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
